mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths come from the shared package.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_read  in  1  instruction-side line read request, held until i_resp.
REQ-005 i_address  in  lc3b_word  instruction-side line address.
REQ-006 i_rdata  out  lc3b_block (128)  instruction-side read data.
REQ-007 i_resp  out  1  instruction-side completion pulse.
REQ-008 d_read, d_write  in  1 each  data-side requests, held until d_resp.
REQ-009 d_address  in  lc3b_word  data-side line address.
REQ-010 d_wdata  in  lc3b_block  data-side write line.
REQ-011 d_rdata  out  lc3b_block  data-side read data.
REQ-012 d_resp  out  1  data-side completion pulse.
REQ-013 pmem_read, pmem_write  out  1 each  physical memory commands.
REQ-014 pmem_address  out  lc3b_word;  pmem_wdata  out  lc3b_block.
REQ-015 pmem_rdata  in  lc3b_block;  pmem_resp  in  1  memory completion.

Function
REQ-016 The FSM SHALL have states IDLE, SERVE_I, SERVE_D.
REQ-017 In IDLE, a request from exactly one side SHALL cause a transition to that side's SERVE state on the next edge.
REQ-018 In IDLE with both sides requesting, the grant SHALL go to the side not granted last; the last-grant flag resets to I, so the first tie goes to D.
REQ-019 On grant, address, read/write direction and wdata SHALL be captured into internal registers; pmem_* SHALL be driven only from these registers.
REQ-020 pmem_read/pmem_write SHALL be asserted in every SERVE cycle, and deasserted in IDLE.
REQ-021 If d_read and d_write are both high at grant, the write SHALL take precedence.
REQ-022 In SERVE_X with pmem_resp=1, X_resp SHALL assert combinationally in the same cycle, X_rdata SHALL equal pmem_rdata, and the state SHALL return to IDLE on the next edge.
REQ-023 X_resp SHALL never assert outside SERVE_X; the non-granted side's resp SHALL stay 0.
REQ-024 A request withdrawn mid-service SHALL NOT abort the transaction; it completes and resp still pulses.
REQ-025 pmem_resp seen in IDLE SHALL be ignored.
REQ-026 The minimum turnaround SHALL be one IDLE cycle between transactions; a back-to-back request from the same side is granted no earlier than the cycle after returning to IDLE.
REQ-027 i_rdata/d_rdata SHALL be 0 when their resp is 0.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, the last-grant flag to I, the captured registers to 0, and all pmem_* and resp outputs to 0, including mid-transaction.
REQ-029 After reset deassertion, a pmem_resp belonging to an aborted transaction SHALL be ignored per REQ-025.

Structure
REQ-030 lc3b_block (128-bit) and the arbiter state enum SHALL live in lc3b_types; lc3b_word is reused.
REQ-031 The block SHALL be one module with no sub-modules.

Verification
REQ-032 The bench SHALL cover the following directed scenarios.
- i_read@0x1000 alone, pmem_resp after 3 cycles, rdata=0xAA..AA -> pmem_read=1, pmem_address=0x1000 for 3 cycles, i_resp 1 cycle with i_rdata=0xAA..AA, d_resp=0.
- Both request from reset (i@0x1000, d_write@0x2000, wdata=0x55..55) -> D served first with pmem_write; I served next with pmem_read@0x1000.
- D and I both pending again after an I grant -> D granted; after a D grant -> I granted; no side is starved over 10 contended rounds.
- i_read dropped one cycle into SERVE_I -> pmem_read held until pmem_resp, i_resp pulses once, then IDLE.
- reset pulsed in SERVE_D, followed by pmem_resp=1 -> all outputs 0 immediately, no d_resp, state IDLE.
- d_read and d_write both high at grant -> only pmem_write is asserted.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache-line block and memory arbiter state.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

endpackage : lc3b_types

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-side and data-side line requests onto one physical
// memory port. Ties alternate between sides; the transaction parameters are
// captured at grant so physical memory sees stable commands for the whole
// service even if the requester changes or drops its inputs.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_read,
  input  lc3b_word  i_address,
  output lc3b_block i_rdata,
  output logic      i_resp,
  input  logic      d_read,
  input  logic      d_write,
  input  lc3b_word  d_address,
  input  lc3b_block d_wdata,
  output lc3b_block d_rdata,
  output logic      d_resp,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_address,
  output lc3b_block pmem_wdata,
  input  lc3b_block pmem_rdata,
  input  logic      pmem_resp
);

  arb_state_t state, next_state;
  logic       last_d;
  lc3b_word   cap_address;
  logic       cap_write;
  lc3b_block  cap_wdata;
  logic       grant_i, grant_d;
  logic       d_req;

  assign d_req = d_read || d_write;

  // State register and last-grant flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i) last_d <= 1'b0;
      else if (grant_d) last_d <= 1'b1;
    end
  end

  // Capture address, direction and write data at grant; a write wins over a
  // simultaneous data-side read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_address <= '0;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
    end else if (grant_i) begin
      cap_address <= i_address;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
    end else if (grant_d) begin
      cap_address <= d_address;
      cap_write   <= d_write;
      cap_wdata   <= d_wdata;
    end
  end

  // Grant selection, next state and completion pulses.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_read && d_req) begin
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i)      next_state = SERVE_I;
        else if (grant_d) next_state = SERVE_D;
      end
      SERVE_I: begin
        i_resp = pmem_resp;
        if (pmem_resp) next_state = IDLE;
      end
      SERVE_D: begin
        d_resp = pmem_resp;
        if (pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign i_rdata      = i_resp ? pmem_rdata : '0;
  assign d_rdata      = d_resp ? pmem_rdata : '0;
  assign pmem_read    = (state != IDLE) && !cap_write;
  assign pmem_write   = (state != IDLE) && cap_write;
  assign pmem_address = cap_address;
  assign pmem_wdata   = cap_wdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;

  localparam logic [127:0] AA = {16{8'hAA}};
  localparam logic [127:0] FIVES = {16{8'h55}};

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: which side owns the memory port (0 none, 1 I, 2 D), who won the
  // previous grant, and the transaction it is working on.
  int          m_owner;
  bit          m_last_was_d;
  logic [15:0] m_addr;
  bit          m_is_write;
  logic [127:0] m_wdata;

  // Values seen at the last sampling point, for directed constant checks.
  logic s_iresp, s_dresp, s_pread, s_pwrite;
  logic [15:0] s_addr;
  logic [127:0] s_irdata, s_wdata;

  task automatic model_reset();
    m_owner = 0; m_last_was_d = 1'b0; m_addr = '0; m_is_write = 1'b0; m_wdata = '0;
  endtask

  // One clock cycle: check the DUT against the model mid-cycle, then advance
  // the model across the rising edge.
  task automatic step();
    int nxt_owner;
    bit want_i, want_d;
    if (reset) model_reset();
    @(negedge clk);
    s_iresp = i_resp; s_dresp = d_resp; s_pread = pmem_read; s_pwrite = pmem_write;
    s_addr = pmem_address; s_irdata = i_rdata; s_wdata = pmem_wdata;
    chk("i_resp", i_resp, (m_owner == 1) && pmem_resp);
    chk("d_resp", d_resp, (m_owner == 2) && pmem_resp);
    chk("i_rdata", i_rdata, ((m_owner == 1) && pmem_resp) ? pmem_rdata : '0);
    chk("d_rdata", d_rdata, ((m_owner == 2) && pmem_resp) ? pmem_rdata : '0);
    chk("pmem_read", pmem_read, (m_owner != 0) && !m_is_write);
    chk("pmem_write", pmem_write, (m_owner != 0) && m_is_write);
    if (m_owner != 0) chk("pmem_address", pmem_address, m_addr);
    if (m_owner != 0 && m_is_write) chk("pmem_wdata", pmem_wdata, m_wdata);
    nxt_owner = m_owner;
    if (m_owner != 0) begin
      if (pmem_resp) nxt_owner = 0;
    end else begin
      want_i = i_read;
      want_d = d_read || d_write;
      if (want_i && want_d) nxt_owner = m_last_was_d ? 1 : 2;
      else if (want_i)      nxt_owner = 1;
      else if (want_d)      nxt_owner = 2;
      if (nxt_owner == 1) begin
        m_addr = i_address; m_is_write = 1'b0; m_last_was_d = 1'b0;
      end else if (nxt_owner == 2) begin
        m_addr = d_address; m_is_write = d_write; m_wdata = d_wdata; m_last_was_d = 1'b1;
      end
    end
    @(posedge clk);
    if (reset) model_reset();
    else m_owner = nxt_owner;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int ni, nd, cyc;
    model_reset();

    // Reset state.
    do_reset();
    chk("rst_pread", s_pread, 1'b0);
    chk("rst_pwrite", s_pwrite, 1'b0);
    chk("rst_addr", s_addr, 16'h0000);

    // Lone instruction read, memory answers on the fourth service cycle.
    i_read = 1'b1; i_address = 16'h1000;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s1_pread", s_pread, 1'b1);
      chk("s1_addr", s_addr, 16'h1000);
    end
    pmem_resp = 1'b1; pmem_rdata = AA;
    step();
    chk("s1_iresp", s_iresp, 1'b1);
    chk("s1_irdata", s_irdata, AA);
    chk("s1_dresp", s_dresp, 1'b0);
    i_read = 1'b0; pmem_resp = 1'b0;
    step();
    chk("s1_idle", s_pread, 1'b0);

    // Both request straight out of reset: data side wins the first tie.
    do_reset();
    i_read = 1'b1; i_address = 16'h1000;
    d_write = 1'b1; d_address = 16'h2000; d_wdata = FIVES;
    step();
    step();
    chk("s2_dfirst", s_pwrite, 1'b1);
    chk("s2_noread", s_pread, 1'b0);
    chk("s2_daddr", s_addr, 16'h2000);
    chk("s2_wdata", s_wdata, FIVES);
    pmem_resp = 1'b1;
    step();
    chk("s2_dresp", s_dresp, 1'b1);
    d_write = 1'b0; pmem_resp = 1'b0;
    step();
    step();
    chk("s2_ithen", s_pread, 1'b1);
    chk("s2_iaddr", s_addr, 16'h1000);
    pmem_resp = 1'b1;
    step();
    chk("s2_iresp", s_iresp, 1'b1);
    i_read = 1'b0; pmem_resp = 1'b0;
    step();

    // Sustained contention: grants must alternate over ten rounds.
    do_reset();
    i_read = 1'b1; d_write = 1'b1;
    ni = 0; nd = 0; cyc = 0;
    while ((ni + nd) < 10 && cyc < 300) begin
      pmem_resp = ($urandom_range(0, 2) == 0);
      step();
      if (s_iresp) ni++;
      if (s_dresp) nd++;
      cyc++;
    end
    chk("s3_rounds", 32'(ni + nd), 32'd10);
    chk("s3_icount", 32'(ni), 32'd5);
    chk("s3_dcount", 32'(nd), 32'd5);
    i_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    step();
    step();

    // Instruction request withdrawn mid-service still completes.
    do_reset();
    i_read = 1'b1; i_address = 16'h3000;
    step();
    step();
    i_read = 1'b0;
    step();
    chk("s4_held", s_pread, 1'b1);
    pmem_resp = 1'b1; pmem_rdata = FIVES;
    step();
    chk("s4_iresp", s_iresp, 1'b1);
    pmem_resp = 1'b0;
    step();
    chk("s4_idle", s_pread, 1'b0);

    // Reset during data service, then a stale memory response.
    d_read = 1'b1; d_address = 16'h4000;
    step();
    step();
    chk("s5_busy", s_pread, 1'b1);
    reset = 1'b1;
    step();
    chk("s5_pread", s_pread, 1'b0);
    chk("s5_addr", s_addr, 16'h0000);
    reset = 1'b0; d_read = 1'b0; pmem_resp = 1'b1;
    step();
    chk("s5_nodresp", s_dresp, 1'b0);
    chk("s5_idle", s_pread, 1'b0);
    pmem_resp = 1'b0;

    // Data read and write together: write only.
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h5000; d_wdata = AA;
    step();
    step();
    chk("s6_write", s_pwrite, 1'b1);
    chk("s6_noread", s_pread, 1'b0);
    pmem_resp = 1'b1;
    step();
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    step();

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      reset     = ($urandom_range(0, 199) == 0);
      i_read    = ($urandom_range(0, 2) != 0);
      i_address = 16'($urandom);
      d_read    = ($urandom_range(0, 2) == 0);
      d_write   = ($urandom_range(0, 2) == 0);
      d_address = 16'($urandom);
      d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
